// File: rtl/aes_subbytes_serial_if.sv
// Handshake bundle for the serial SubBytes engine.
// Carries the input-state channel and the output-state channel.
interface aes_subbytes_serial_if #(
    parameter int N_BYTES = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_encrypt;
    logic [8*N_BYTES-1:0]   in_state;
    logic                   out_valid;
    logic                   out_ready;
    logic [8*N_BYTES-1:0]   out_state;

    modport master (
        output in_valid, in_encrypt, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_encrypt, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/aes_subbytes_serial.sv
// Serial AES SubBytes: streams one state byte per cycle through a single
// external S-box and reassembles the substituted bytes into an output state.
module aes_subbytes_serial #(
    parameter int N_BYTES      = 16,
    parameter int SBOX_LATENCY = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_subbytes_serial_if.slave bus,
    output logic                 sbox_encrypt,
    output logic [7:0]           sbox_byte_in,
    input  logic [7:0]           sbox_byte_out
);
    localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int CNT_W = (SBOX_LATENCY > 1) ? $clog2(SBOX_LATENCY) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((SBOX_LATENCY > 0) ? SBOX_LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                     state_reg, state_next;
    logic [IDX_W-1:0]           idx_reg, idx_next;
    logic [CNT_W-1:0]           drain_reg, drain_next;
    logic                       enc_reg;
    logic [N_BYTES-1:0][7:0]    src_reg;
    logic [N_BYTES-1:0][7:0]    result_reg;

    logic                       accept;
    logic                       issue;
    logic                       in_ready_w;
    logic                       out_valid_w;
    logic [7:0]                 byte_in_w;
    logic                       cap_valid;
    logic [IDX_W-1:0]           cap_idx;

    // Byte 0 sits in the most significant position, hence the reversed index.
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        drain_next  = drain_reg;
        accept      = 1'b0;
        issue       = 1'b0;
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;
        byte_in_w   = 8'h00;
        case (state_reg)
            IDLE: begin
                in_ready_w = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    idx_next   = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issue     = 1'b1;
                byte_in_w = src_reg[IDX_LAST - idx_reg];
                if (idx_reg == IDX_LAST) begin
                    idx_next   = '0;
                    drain_next = '0;
                    state_next = (SBOX_LATENCY > 0) ? DRAIN : DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_reg == DRAIN_LAST) begin
                    state_next = DONE;
                end else begin
                    drain_next = drain_reg + 1'b1;
                end
            end
            DONE: begin
                out_valid_w = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            drain_reg <= '0;
            enc_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            drain_reg <= drain_next;
            if (accept) begin
                enc_reg <= bus.in_encrypt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            src_reg <= bus.in_state;
        end
    end

    // Capture follows the issue stream delayed by the S-box latency, so it
    // completes on its own regardless of which state the FSM is in.
    generate
        if (SBOX_LATENCY == 0) begin : g_comb_capture
            assign cap_valid = issue;
            assign cap_idx   = idx_reg;
        end else begin : g_pipe_capture
            logic [SBOX_LATENCY-1:0]            pipe_valid_reg;
            logic [SBOX_LATENCY-1:0][IDX_W-1:0] pipe_idx_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_valid_reg <= '0;
                    pipe_idx_reg   <= '0;
                end else begin
                    pipe_valid_reg[0] <= issue;
                    pipe_idx_reg[0]   <= idx_reg;
                    for (int k = 1; k < SBOX_LATENCY; k++) begin
                        pipe_valid_reg[k] <= pipe_valid_reg[k-1];
                        pipe_idx_reg[k]   <= pipe_idx_reg[k-1];
                    end
                end
            end

            assign cap_valid = pipe_valid_reg[SBOX_LATENCY-1];
            assign cap_idx   = pipe_idx_reg[SBOX_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg <= '0;
        end else if (cap_valid) begin
            result_reg[IDX_LAST - cap_idx] <= sbox_byte_out;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_state = result_reg;
    assign sbox_byte_in  = byte_in_w;
    assign sbox_encrypt  = enc_reg;
endmodule
